fir_tap_accumulator: RTL and testbench

Sequential accumulation stage that sums a stream of signed tap products into one FIR output sample per NUM_TAPS inputs. Sits directly downstream of the tap multipliers and wraps a single `RCA_adder` instance as its add datapath; the adder's sum is registered back into the accumulator each accepted cycle. A valid/ready handshake on both sides lets the filter back-pressure and resynchronise on frame boundaries.

---
 rtl/fir_pkg.sv | 20 ++
 rtl/RCA_adder.sv | 28 ++
 rtl/fir_tap_accumulator.sv | 123 ++++++++++++
 tb/tb_fir_tap_accumulator.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared state encoding and default sizing for the FIR tap accumulator
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } fir_state_t;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ACC_WIDTH  = 20;
    localparam int DEF_NUM_TAPS   = 8;

    function automatic int cnt_width(input int taps);
        return (taps < 2) ? 1 : $clog2(taps);
    endfunction

    localparam int DEF_CNT_WIDTH = cnt_width(DEF_NUM_TAPS);

endpackage

// File: rtl/RCA_adder.sv
// rtl/RCA_adder.sv - combinational ripple-carry adder built from a chain of full adders
module RCA_adder
    import fir_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_ACC_WIDTH
) (
    input  logic [BIT_WIDTH-1:0] add_1,
    input  logic [BIT_WIDTH-1:0] add_2,
    input  logic                 c_in,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 c_out
);

    logic [BIT_WIDTH:0] w_carry;

    assign w_carry[0] = c_in;

    genvar i;
    generate
        for (i = 0; i < BIT_WIDTH; i++) begin : g_fa
            assign sum[i]       = add_1[i] ^ add_2[i] ^ w_carry[i];
            assign w_carry[i+1] = (add_1[i] & add_2[i]) | (w_carry[i] & (add_1[i] ^ add_2[i]));
        end
    endgenerate

    assign c_out = w_carry[BIT_WIDTH];

endmodule

// File: rtl/fir_tap_accumulator.sv
// rtl/fir_tap_accumulator.sv - sums NUM_TAPS signed products into one output sample
module fir_tap_accumulator
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int NUM_TAPS   = DEF_NUM_TAPS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  out_ovf
);

    localparam int                CNT_W    = cnt_width(NUM_TAPS);
    localparam logic [CNT_W-1:0]  LAST_TAP = CNT_W'(NUM_TAPS - 1);

    fir_state_t             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic                   r_ovf_sticky;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [ACC_WIDTH-1:0]   r_out_data;
    logic                   r_out_ovf;

    logic [ACC_WIDTH-1:0]   w_add_1;
    logic [ACC_WIDTH-1:0]   w_add_2;
    logic [ACC_WIDTH-1:0]   w_sum;
    logic                   w_unused_c_out;
    logic                   w_add_ovf;
    logic                   w_frame_ovf;
    logic                   w_accept;

    // IDLE feeds zero so a stale accumulator never leaks into a new frame
    assign w_add_1 = (r_state == ST_IDLE) ? '0 : r_acc;
    assign w_add_2 = ACC_WIDTH'($signed(in_data));

    RCA_adder #(
        .BIT_WIDTH (ACC_WIDTH)
    ) u_adder (
        .add_1 (w_add_1),
        .add_2 (w_add_2),
        .c_in  (1'b0),
        .sum   (w_sum),
        .c_out (w_unused_c_out)
    );

    assign w_add_ovf   = (w_add_1[ACC_WIDTH-1] == w_add_2[ACC_WIDTH-1]) &&
                         (w_sum[ACC_WIDTH-1]   != w_add_1[ACC_WIDTH-1]);
    assign w_frame_ovf = ((r_state == ST_IDLE) ? 1'b0 : r_ovf_sticky) | w_add_ovf;
    assign w_accept    = in_valid & r_in_ready & ~clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_ovf_sticky <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_ovf    <= 1'b0;
        end else if (clear) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_ovf_sticky <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_acc        <= w_sum;
                        r_ovf_sticky <= w_frame_ovf;
                        r_cnt        <= CNT_W'(1);
                        r_state      <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc        <= w_sum;
                        r_ovf_sticky <= w_frame_ovf;
                        if (r_cnt == LAST_TAP) begin
                            r_cnt       <= '0;
                            r_state     <= ST_HOLD;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_sum;
                            r_out_ovf   <= w_frame_ovf;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_fir_tap_accumulator.sv
// tb/tb_fir_tap_accumulator.sv - scoreboard bench for fir_tap_accumulator at 20-bit and 16-bit accumulator widths
module tb_fir_tap_accumulator;

    localparam int NT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        rdy20, vld20, ovf20;
    logic [19:0] data20;
    logic        rdy16, vld16, ovf16;
    logic [15:0] data16;

    always #5 clk = ~clk;

    fir_tap_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(20), .NUM_TAPS(NT)) u_dut20 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(rdy20), .in_data(in_data),
        .out_valid(vld20), .out_ready(out_ready), .out_data(data20), .out_ovf(ovf20)
    );

    fir_tap_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(16), .NUM_TAPS(NT)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(rdy16), .in_data(in_data),
        .out_valid(vld16), .out_ready(out_ready), .out_data(data16), .out_ovf(ovf16)
    );

    typedef struct {
        longint d20;
        bit     o20;
        longint d16;
        bit     o16;
    } exp_t;

    exp_t   exp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    bit     m_hold = 0;
    int     m_taken = 0;
    longint m_acc20 = 0, m_acc16 = 0;
    bit     m_ovf20 = 0, m_ovf16 = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint wrap(input longint s, input int aw);
        longint m = longint'(1) << aw;
        longint r = s % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    function automatic bit out_of_range(input longint s, input int aw);
        longint hi = (longint'(1) << (aw - 1)) - 1;
        return (s > hi) || (s < -hi - 1);
    endfunction

    function automatic longint mask(input longint v, input int aw);
        return v & ((longint'(1) << aw) - 1);
    endfunction

    // reference model: frame-level arithmetic on true integers, wrapped per add
    initial forever begin
        longint v, s;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_hold = 0; m_taken = 0;
            exp_q.delete();
        end else if (clear) begin
            m_hold = 0; m_taken = 0;
            exp_q.delete();
        end else if (m_hold) begin
            if (out_ready) m_hold = 0;
        end else if (in_valid) begin
            v = longint'($signed(in_data));
            if (m_taken == 0) begin
                m_acc20 = 0; m_acc16 = 0; m_ovf20 = 0; m_ovf16 = 0;
            end
            s = m_acc20 + v;
            m_ovf20 |= out_of_range(s, 20);
            m_acc20 = wrap(s, 20);
            s = m_acc16 + v;
            m_ovf16 |= out_of_range(s, 16);
            m_acc16 = wrap(s, 16);
            m_taken++;
            if (m_taken == NT) begin
                exp_q.push_back('{mask(m_acc20, 20), m_ovf20, mask(m_acc16, 16), m_ovf16});
                m_hold = 1;
                m_taken = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("in_ready20", rdy20, !m_hold);
            check("in_ready16", rdy16, !m_hold);
            check("out_valid20", vld20, m_hold);
            check("out_valid16", vld16, m_hold);
            if (vld20) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    check("out_data20", data20, exp_q[0].d20);
                    check("out_ovf20", ovf20, exp_q[0].o20);
                    check("out_data16", data16, exp_q[0].d16);
                    check("out_ovf16", ovf16, exp_q[0].o16);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc(input bit v, input int d, input bit c, input bit r);
        in_valid  = v;
        in_data   = 16'(d);
        clear     = c;
        out_ready = r;
        @(posedge clk);
        #2;
    endtask

    task automatic frame(input int a, input int b, input int c, input int d,
                         input int gap, input bit r);
        int vals[4];
        vals = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            cyc(1, vals[i], 0, r);
            for (int g = 0; g < gap; g++) cyc(0, 0, 0, r);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready20"}, rdy20, 1);
        check({tag, "_out_valid20"}, vld20, 0);
        check({tag, "_out_data20"}, data20, 0);
        check({tag, "_out_ovf20"}, ovf20, 0);
        check({tag, "_in_ready16"}, rdy16, 1);
        check({tag, "_out_valid16"}, vld16, 0);
        check({tag, "_out_data16"}, data16, 0);
        check({tag, "_out_ovf16"}, ovf16, 0);
    endtask

    task automatic async_reset(input string tag);
        in_valid = 0; clear = 0; out_ready = 0;
        #1;
        rst_n = 0;
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        #1;
        rst_n = 1;
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        rst_n = 1;

        frame(1, 2, 3, 4, 0, 1);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);

        frame(-5, 3, -1, -7, 2, 1);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);

        frame(32'h7FFF, 32'h7FFF, 0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        frame(1, 1, 1, 1, 0, 1);
        cyc(0, 0, 0, 1);

        frame(5, 6, 7, 8, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 99, 0, 0);
        cyc(1, 10, 0, 1);
        frame(11, 12, 13, 14, 0, 1);
        cyc(0, 0, 0, 1);

        cyc(1, 7, 0, 1); cyc(1, 9, 0, 1);
        cyc(1, 5, 1, 1);
        frame(1, 1, 1, 1, 0, 1);
        cyc(0, 0, 0, 1);

        cyc(1, 3, 0, 1); cyc(1, 4, 0, 1);
        async_reset("rst_midframe");
        frame(2, 2, 2, 2, 0, 1);
        cyc(0, 0, 0, 1);

        frame(100, 200, 300, 400, 0, 0);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        async_reset("rst_hold");
        frame(1, 2, 3, 4, 0, 1);
        cyc(0, 0, 0, 1);

        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 99) < 75, int'($urandom),
                $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 60);
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
